lyr1_mac: RTL and testbench
===========================

// Module: lyr1_mac
// PURPOSE
//  Serial two-neuron hidden layer. Streams N_IN input activations, each paired with one
//  weight per neuron, and accumulates both dot products in parallel. It then adds a bias,
//  rounds, saturates, applies an optional ReLU and presents the two results as d1/d2.
//  Sits directly upstream of the 2-input output neuron (d1/d2 feed its data inputs).
// PARAMETERS
//  N_IN     4   input beats per vector (>=2)
//  DW       16  data/weight/bias width, signed two's complement
//  FRAC     8   fractional bits (Q8.8 at defaults)
//  ACT_RELU 1   1: clamp negative results to 0; 0: pass signed result
// PORTS
//  clk       in   1   clock, all logic on rising edge
//  rst       in   1   synchronous reset, active-high
//  in_valid  in   1   input beat valid
//  in_ready  out  1   block can accept a beat
//  in_data   in   DW  input activation x[k]
//  in_w1     in   DW  weight for neuron 1, beat k
//  in_w2     in   DW  weight for neuron 2, beat k
//  b1, b2    in   DW  biases, static; sampled in FINAL
//  out_valid out  1   d1/d2 valid
//  out_ready in   1   consumer accepts d1/d2
//  d1, d2    out  DW  neuron outputs, Q(DW-FRAC).FRAC
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, acc1=acc2=0, out_valid=0, d1=d2=0. in_ready=1 the cycle after rst drops.
//  - Beat accepted when in_valid && in_ready. Each product is the full 2*DW signed product.
//  - Accumulator width ACC_W = 2*DW + $clog2(N_IN) + 1. The accumulator never overflows.
//  - FSM:
//    IDLE : in_ready=1; on beat: acc=prod (load, not add), cnt=1, ->ACC.
//    ACC  : in_ready=1; on beat: acc+=prod, cnt++. If the beat is the last (cnt==N_IN-1), ->FINAL.
//           No beat: hold all state (bubbles allowed).
//    FINAL: in_ready=0. s = acc + (b <<< FRAC) + (1 << (FRAC-1)); r = s >>> FRAC (arithmetic).
//           Saturate r to [-2^(DW-1), 2^(DW-1)-1]. If ACT_RELU && r<0, r=0.
//           Register d1/d2, out_valid=1, ->OUT.
//    OUT  : in_ready=0; d1/d2/out_valid held stable until out_ready.
//           On out_valid && out_ready: out_valid=0, ->IDLE.
//  - Latency: out_valid rises 2 cycles after the last beat is accepted.
//    Max throughput: one vector per N_IN+2 cycles.
//  - Rounding is round-half-up. Saturation applies only at the output, never in the accumulator.
//  - in_ready is combinational from state only; it must not depend on in_valid.
//  - rst at any time, including mid-vector or in OUT, discards the partial vector and returns
//    to the reset values. No stale partial sum may leak into the next vector.
//  - Biases are read only in FINAL. Changes to b1/b2 at other times have no effect.
// STRUCTURE
//  - Shared include mac_defs.vh: Q-format constants (DW, FRAC), the FSM state encodings
//    (IDLE/ACC/FINAL/OUT, 2 bits) and the saturate/round macros shared with the output stage.
//  - One sub-module, mac_unit (one per neuron, x2): signed DW x DW multiply plus an
//    ACC_W accumulator, with load/add enable. Bias, round, saturate and ReLU sit in mac_unit's
//    finalize path, controlled by an fsm input.
//  - The FSM and beat counter live in lyr1_mac.
// TESTING
//  - Basic: N_IN=4, x=0x0100 x4, w1=0x0100, w2=0x0080, b1=0, b2=0x0100
//    -> d1=0x0400, d2=0x0300, out_valid 2 cycles after beat 4.
//  - Saturation and ReLU:
//    x=w1=0x7FFF x4 -> d1=0x7FFF.
//    x=0x0100, w2=0xFF00, b2=0: ACT_RELU=1 -> d2=0x0000; ACT_RELU=0 -> d2=0xFC00.
//  - Rounding: beat1 x=0x0001, w1=0x0080; beats 2-4 zero; b1=0 -> d1=0x0001 (half rounds up).
//  - Backpressure: hold out_ready=0 for 5 cycles with in_valid=1
//    -> in_ready=0 and d1/d2 stable throughout. The next vector is accepted only after the handshake.
//  - Bubbles: the basic vector with in_valid low 1-3 cycles between beats -> identical d1/d2.
//  - Reset mid-vector: assert rst after 2 beats, then send the basic vector
//    -> out_valid=0 during and after reset; result equals the basic case exactly.

Source files
------------

// File: rtl/lyr1_mac_pkg.sv
// Shared definitions for the two-neuron serial hidden layer: FSM state
// encoding and the accumulator sizing rule used by the per-neuron MAC.
package lyr1_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Full product width plus growth for N_IN additions plus one spare bit,
  // so the running sum can never wrap.
  function automatic int acc_width(input int dw, input int n_in);
    return 2 * dw + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/lyr1_mac_unit.sv
// One neuron: signed DW x DW multiply feeding an ACC_W accumulator with
// load/add enables, plus the bias / round-half-up / saturate / ReLU path
// that registers the neuron output when the controller asks to finalize.
module lyr1_mac_unit
  import lyr1_mac_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int DW       = 16,
  parameter int FRAC     = 8,
  parameter int ACT_RELU = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          add_i,
  input  logic          fin_i,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] w_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] d_o
);

  localparam int ACC_W = acc_width(DW, N_IN);
  // One extra bit so accumulator + shifted bias + rounding constant cannot wrap.
  localparam int S_W   = ACC_W + 1;

  localparam logic signed [S_W-1:0] RND_C = S_W'(1) << (FRAC - 1);
  localparam logic signed [S_W-1:0] MAX_C = S_W'({(DW-1){1'b1}});
  localparam logic signed [S_W-1:0] MIN_C = ~MAX_C;

  logic signed [2*DW-1:0]  x_ext_s;
  logic signed [2*DW-1:0]  w_ext_s;
  logic signed [2*DW-1:0]  prod_s;
  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [S_W-1:0]   acc_ext_s;
  logic signed [S_W-1:0]   bias_ext_s;
  logic signed [S_W-1:0]   bias_sh_s;
  logic signed [S_W-1:0]   sum_s;
  logic signed [S_W-1:0]   shr_s;
  logic        [DW-1:0]    sat_s;
  logic        [DW-1:0]    res_s;
  logic        [DW-1:0]    d_q;
  logic        [DW-1:0]    d_d;

  // Operands sign-extended to full product width; low 2*DW bits are exact.
  assign x_ext_s    = {{DW{x_i[DW-1]}}, x_i};
  assign w_ext_s    = {{DW{w_i[DW-1]}}, w_i};
  assign prod_s     = x_ext_s * w_ext_s;
  assign prod_ext_s = {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};

  // Accumulator next state: first beat loads so no earlier sum can leak in.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = prod_ext_s;
    end else if (add_i) begin
      acc_d = acc_q + prod_ext_s;
    end else begin
      acc_d = acc_q;
    end
  end

  assign acc_ext_s  = {{(S_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign bias_ext_s = {{(S_W-DW){b_i[DW-1]}}, b_i};
  assign bias_sh_s  = bias_ext_s <<< FRAC;
  assign sum_s      = acc_ext_s + bias_sh_s + RND_C;
  assign shr_s      = sum_s >>> FRAC;

  // Finalize path: clamp to the output range, then optional ReLU.
  always_comb begin
    sat_s = shr_s[DW-1:0];
    if (shr_s > MAX_C) begin
      sat_s = MAX_C[DW-1:0];
    end else if (shr_s < MIN_C) begin
      sat_s = MIN_C[DW-1:0];
    end else begin
      sat_s = shr_s[DW-1:0];
    end
    res_s = sat_s;
    if ((ACT_RELU != 0) && sat_s[DW-1]) begin
      res_s = '0;
    end else begin
      res_s = sat_s;
    end
  end

  // Output register only updates in the finalize cycle, so it holds under backpressure.
  always_comb begin
    d_d = d_q;
    if (fin_i) begin
      d_d = res_s;
    end else begin
      d_d = d_q;
    end
  end

  // Accumulator and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      d_q   <= '0;
    end else begin
      acc_q <= acc_d;
      d_q   <= d_d;
    end
  end

  assign d_o = d_q;

endmodule

// File: rtl/lyr1_mac.sv
// Serial two-neuron hidden layer: accepts N_IN beats (activation plus one
// weight per neuron), accumulates both dot products, then presents the
// biased, rounded, saturated results on d1/d2 with a valid/ready handshake.
module lyr1_mac
  import lyr1_mac_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int DW       = 16,
  parameter int FRAC     = 8,
  parameter int ACT_RELU = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [DW-1:0] in_w1,
  input  logic [DW-1:0] in_w2,
  input  logic [DW-1:0] b1,
  input  logic [DW-1:0] b2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] d1,
  output logic [DW-1:0] d2
);

  localparam int              CNT_W    = $clog2(N_IN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               out_valid_q;
  logic               out_valid_d;
  logic               beat_s;
  logic               load_s;
  logic               add_s;
  logic               fin_s;

  // Ready depends on state alone, never on in_valid.
  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ACC);
  assign beat_s   = in_valid && in_ready;

  // Next-state, beat counter and MAC control decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    load_s      = 1'b0;
    add_s       = 1'b0;
    fin_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat_s) begin
          load_s  = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = ST_ACC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (beat_s) begin
          add_s = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_FINAL;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_FINAL: begin
        fin_s       = 1'b1;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        cnt_d       = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  lyr1_mac_unit #(
    .N_IN(N_IN), .DW(DW), .FRAC(FRAC), .ACT_RELU(ACT_RELU)
  ) u_neuron1 (
    .clk(clk), .rst(rst), .load_i(load_s), .add_i(add_s), .fin_i(fin_s),
    .x_i(in_data), .w_i(in_w1), .b_i(b1), .d_o(d1)
  );

  lyr1_mac_unit #(
    .N_IN(N_IN), .DW(DW), .FRAC(FRAC), .ACT_RELU(ACT_RELU)
  ) u_neuron2 (
    .clk(clk), .rst(rst), .load_i(load_s), .add_i(add_s), .fin_i(fin_s),
    .x_i(in_data), .w_i(in_w2), .b_i(b2), .d_o(d2)
  );

endmodule

// File: tb/tb_lyr1_mac.sv
// Bench for lyr1_mac: one ReLU instance and one linear instance share all
// inputs; results are compared with a plain-arithmetic dot-product model.
module tb_lyr1_mac;

  localparam int N_IN = 4;
  localparam int DW   = 16;
  localparam int FRAC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data, in_w1, in_w2, b1, b2;
  logic          in_ready, out_valid, in_ready_l, out_valid_l;
  logic [DW-1:0] d1, d2, d1_l, d2_l;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] vx[N_IN];
  logic [DW-1:0] vw1[N_IN];
  logic [DW-1:0] vw2[N_IN];
  logic [DW-1:0] vb1, vb2;

  always #5 clk = ~clk;

  lyr1_mac #(.N_IN(N_IN), .DW(DW), .FRAC(FRAC), .ACT_RELU(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_w1(in_w1), .in_w2(in_w2), .b1(b1), .b2(b2),
    .out_valid(out_valid), .out_ready(out_ready), .d1(d1), .d2(d2)
  );

  lyr1_mac #(.N_IN(N_IN), .DW(DW), .FRAC(FRAC), .ACT_RELU(0)) dut_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .in_w1(in_w1), .in_w2(in_w2), .b1(b1), .b2(b2),
    .out_valid(out_valid_l), .out_ready(out_ready), .d1(d1_l), .d2(d2_l)
  );

  // Reference neuron: exact integer dot product, bias scaled into Q format,
  // round half up, floor shift, clamp, optional ReLU.
  function automatic logic [DW-1:0] ref_neuron(input int sel, input bit relu);
    longint acc;
    longint s;
    longint r;
    acc = 0;
    for (int i = 0; i < N_IN; i++) begin
      acc += longint'($signed(vx[i])) * longint'($signed(sel == 1 ? vw1[i] : vw2[i]));
    end
    s = acc + longint'($signed(sel == 1 ? vb1 : vb2)) * (longint'(1) <<< FRAC)
        + (longint'(1) <<< (FRAC - 1));
    r = s >>> FRAC;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rnd16();
    if ($urandom_range(1, 0) == 1) return 16'($urandom);
    else return 16'($urandom_range(2048, 0)) - 16'd1024;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_basic();
    for (int i = 0; i < N_IN; i++) begin
      vx[i] = 16'h0100; vw1[i] = 16'h0100; vw2[i] = 16'h0080;
    end
    vb1 = 16'h0000; vb2 = 16'h0100;
    b1 = vb1; b2 = vb2;
  endtask

  task automatic send_beats(input int nbeats, input int max_bubble);
    int nb;
    int w;
    for (int k = 0; k < nbeats; k++) begin
      nb = (max_bubble > 0) ? int'($urandom_range(max_bubble, 1)) : 0;
      if (nb > 0) begin
        in_valid = 1'b0;
        repeat (nb) step();
      end
      in_data = vx[k]; in_w1 = vw1[k]; in_w2 = vw2[k];
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin step(); w++; end
      if (!in_ready) begin
        checks++; failures++;
        $display("FAIL beat_accept: in_ready=%b required 1 within 50 cycles", in_ready);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin step(); lat++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_w1 = '0; in_w2 = '0; b1 = '0; b2 = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (d1 !== 16'h0000) begin failures++; $display("FAIL reset_d1 got=%h exp=0000", d1); end
    checks++; if (d2 !== 16'h0000) begin failures++; $display("FAIL reset_d2 got=%h exp=0000", d2); end
  endtask

  task automatic test_basic();
    int lat;
    set_basic();
    send_beats(N_IN, 0);
    wait_valid(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    checks++; if (d1 !== 16'h0400) begin failures++; $display("FAIL basic_d1 got=%h exp=0400", d1); end
    checks++; if (d2 !== 16'h0300) begin failures++; $display("FAIL basic_d2 got=%h exp=0300", d2); end
    checks++; if (d2_l !== 16'h0300) begin failures++; $display("FAIL basic_d2_lin got=%h exp=0300", d2_l); end
    handshake();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_out_valid_drop got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready_back got=%b exp=1", in_ready); end
  endtask

  task automatic test_saturation_relu();
    int lat;
    for (int i = 0; i < N_IN; i++) begin
      vx[i] = 16'h7FFF; vw1[i] = 16'h7FFF; vw2[i] = 16'h0000;
    end
    vb1 = 16'h0000; vb2 = 16'h0000; b1 = vb1; b2 = vb2;
    send_beats(N_IN, 0);
    wait_valid(lat);
    checks++; if (d1 !== 16'h7FFF) begin failures++; $display("FAIL sat_d1 got=%h exp=7fff", d1); end
    checks++; if (d1_l !== 16'h7FFF) begin failures++; $display("FAIL sat_d1_lin got=%h exp=7fff", d1_l); end
    handshake();
    for (int i = 0; i < N_IN; i++) begin
      vx[i] = 16'h0100; vw1[i] = 16'h0000; vw2[i] = 16'hFF00;
    end
    send_beats(N_IN, 0);
    wait_valid(lat);
    checks++; if (d2 !== 16'h0000) begin failures++; $display("FAIL relu_d2 got=%h exp=0000", d2); end
    checks++; if (d2_l !== 16'hFC00) begin failures++; $display("FAIL linear_d2 got=%h exp=fc00", d2_l); end
    handshake();
  endtask

  task automatic test_rounding();
    int lat;
    for (int i = 0; i < N_IN; i++) begin
      vx[i] = 16'h0000; vw1[i] = 16'h0000; vw2[i] = 16'h0000;
    end
    vx[0] = 16'h0001; vw1[0] = 16'h0080; vw2[0] = 16'hFF80;
    vb1 = 16'h0000; vb2 = 16'h0000; b1 = vb1; b2 = vb2;
    send_beats(N_IN, 0);
    wait_valid(lat);
    checks++; if (d1 !== 16'h0001) begin failures++; $display("FAIL round_half_up got=%h exp=0001", d1); end
    checks++; if (d2_l !== 16'h0000) begin failures++; $display("FAIL round_neg_half got=%h exp=0000", d2_l); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [DW-1:0] c1, c2;
    set_basic();
    send_beats(N_IN, 0);
    wait_valid(lat);
    c1 = d1; c2 = d2;
    checks++; if (c1 !== 16'h0400) begin failures++; $display("FAIL bp_d1 got=%h exp=0400", c1); end
    in_valid = 1'b1; in_data = 16'h1234; in_w1 = 16'h0321; in_w2 = 16'h7000;
    for (int c = 0; c < 5; c++) begin
      b1 = rnd16(); b2 = rnd16();
      step();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", c, out_valid); end
      checks++; if ({d1, d2} !== {c1, c2}) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h %h exp=%h %h", c, d1, d2, c1, c2); end
    end
    in_valid = 1'b0; b1 = vb1; b2 = vb2;
    handshake();
    send_beats(N_IN, 0);
    wait_valid(lat);
    checks++; if ({d1, d2} !== {16'h0400, 16'h0300}) begin failures++; $display("FAIL bp_next_vec got=%h %h exp=0400 0300", d1, d2); end
    handshake();
  endtask

  task automatic test_bubbles();
    int lat;
    set_basic();
    send_beats(N_IN, 3);
    wait_valid(lat);
    checks++; if ({d1, d2} !== {16'h0400, 16'h0300}) begin failures++; $display("FAIL bubbles got=%h %h exp=0400 0300", d1, d2); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    set_basic();
    for (int i = 0; i < N_IN; i++) begin vx[i] = 16'h0F00; vw1[i] = 16'h0555; end
    send_beats(2, 0);
    rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_during got=%b exp=0", out_valid); end
    step();
    rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    set_basic();
    send_beats(N_IN, 0);
    wait_valid(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rstmid_latency got=%0d exp=2", lat); end
    checks++; if ({d1, d2} !== {16'h0400, 16'h0300}) begin failures++; $display("FAIL rstmid_result got=%h %h exp=0400 0300", d1, d2); end
    handshake();
  endtask

  task automatic test_random();
    int lat;
    logic [DW-1:0] e1, e2, e1l, e2l;
    for (int n = 0; n < 15; n++) begin
      for (int i = 0; i < N_IN; i++) begin
        vx[i] = rnd16(); vw1[i] = rnd16(); vw2[i] = rnd16();
      end
      vb1 = rnd16(); vb2 = rnd16();
      b1 = rnd16(); b2 = rnd16();
      send_beats(N_IN, int'($urandom_range(3, 0)));
      b1 = vb1; b2 = vb2;
      e1 = ref_neuron(1, 1'b1); e2 = ref_neuron(2, 1'b1);
      e1l = ref_neuron(1, 1'b0); e2l = ref_neuron(2, 1'b0);
      wait_valid(lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=2", n, lat); end
      checks++; if ({d1, d2} !== {e1, e2}) begin failures++; $display("FAIL rand_relu n=%0d got=%h %h exp=%h %h", n, d1, d2, e1, e2); end
      checks++; if ({d1_l, d2_l} !== {e1l, e2l}) begin failures++; $display("FAIL rand_linear n=%0d got=%h %h exp=%h %h", n, d1_l, d2_l, e1l, e2l); end
      repeat ($urandom_range(3, 0)) step();
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation_relu();
    test_rounding();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
